retro_bus_stall: RTL
====================

# retro_bus_stall

Core-side bus adapter that sits directly upstream of the CATC clock-enable controller and drives its `Delay` input. It accepts the emulated core's reads and writes on the core's own clock enable and forwards them to the external memory port. Writes are posted through a 2-entry buffer; reads stall the core until the data arrives. While an access is still outstanding when the core would need it, it holds `Delay` high. CATC then withholds clock enables and later catches up the lost reference ticks.

## Interface
Parameters:
- AddrWidth, 24, core/memory address width
- DataWidth, 8, data width
- TimeoutCycles, 4096, consecutive `Delay`-high Clk cycles before `Timeout` sets

Ports:
- Clk  in  1  FPGA core clock
- Reset  in  1  synchronous, active-high
- ClkEn  in  1  core clock enable (CATC `ClkEnOut`); core bus sampled only when high
- CoreRd  in  1  read request, valid when ClkEn
- CoreWr  in  1  write request, valid when ClkEn
- CoreAddr  in  AddrWidth  access address
- CoreWData  in  DataWidth  write data
- CoreRData  out  DataWidth  read data, stable until next read completes
- Delay  out  1  registered stall request to CATC
- MemReq  out  1  memory request valid
- MemWe  out  1  1 = write, 0 = read
- MemAddr  out  AddrWidth  memory address
- MemWData  out  DataWidth  memory write data
- MemReady  in  1  memory accepts request this cycle (MemReq && MemReady)
- MemRValid  in  1  read data valid, ≥1 cycle after read accept
- MemRData  in  DataWidth  read data
- StallCount  out  32  cycles with Delay high, saturating
- Timeout  out  1  sticky; set after TimeoutCycles consecutive Delay cycles

## Operation
- Reset state:
  - State machine in IDLE; write FIFO empty.
  - Delay, MemReq, MemWe, CoreRData, StallCount and Timeout are all 0.
  - MemAddr/MemWData are 0.
- Core requests are sampled only on `ClkEn=1`. If CoreRd and CoreWr are both high, the access is a write and the read is dropped.
- Write FIFO: depth 2, in order.
  - A write pushes {addr, data}.
  - The FIFO head drives the memory port (MemReq=1, MemWe=1) whenever the FSM is not in RISSUE/RWAIT.
  - The head pops on MemReq && MemReady.
  - A simultaneous push and pop on a full FIFO is legal and does not stall.
- States:
  - IDLE: no stall.
  - WFULL: a write arrived with the FIFO full and no pop that cycle. The write is held in a side register and Delay=1. When a slot frees, the held write is pushed, Delay clears, and the FSM returns to IDLE.
  - RDRAIN: the read missed forwarding while the FIFO is non-empty. Delay=1; the FSM waits for the FIFO to empty, then moves to RISSUE.
  - RISSUE: MemReq=1, MemWe=0, MemAddr=captured address, held stable until MemReady. Then moves to RWAIT.
  - RWAIT: on MemRValid, CoreRData←MemRData, Delay←0, FSM→IDLE.
- Reads from IDLE:
  - If a FIFO entry matches CoreAddr, forward the newest matching entry's data into CoreRData next cycle, with no stall and no memory access.
  - Otherwise, go to RDRAIN if the FIFO is non-empty, else RISSUE.
  - Delay=1 from the next cycle in either case.
- ClkEn is never expected while Delay=1, because CATC gates it. Any ClkEn requests sampled then are ignored.
- MemRValid outside RWAIT is ignored. This covers a stale response after a mid-transaction Reset.
- Reset mid-operation: the FSM returns to IDLE and the FIFO is discarded; unissued writes are lost.
- StallCount increments each Clk cycle with Delay=1 and saturates at 0xFFFFFFFF.
- Timeout:
  - A counter of consecutive Delay=1 cycles is cleared whenever Delay=0.
  - When it reaches TimeoutCycles, Timeout sets and stays set until Reset.
  - Timeout does not alter stall behaviour.

## Timing
- Delay is registered:
  - It rises the Clk cycle after the ClkEn sample that causes the stall.
  - It falls the cycle after MemRValid is captured (read) or the slot frees (WFULL).
  - CATC's minimum ClkEn spacing must be ≥2 Clk cycles.
- Forwarded read: CoreRData is valid 1 cycle after the ClkEn sample.
- Uncached read with an empty FIFO and MemReady=1 immediately:
  - MemReq is asserted 1 cycle after the sample.
  - CoreRData and the Delay fall occur 1 cycle after MemRValid.
- A write push appears on MemReq the cycle after the ClkEn sample.

## Test plan
- Write 0x12 to 0x000100 with MemReady=1 → MemReq/MemWe=1, MemAddr=0x000100, MemWData=0x12 one cycle later; Delay stays 0.
- Three back-to-back writes (ClkEn every 2 cycles) with MemReady=0 → third write enters WFULL with Delay=1. Raise MemReady → all three writes are issued in order, and Delay clears after the first pop.
- Write 0x55 to 0x000200, MemReady=0, then read 0x000200 → CoreRData=0x55 one cycle later; no read MemReq; Delay 0.
- Read 0x001000 with MemRValid 5 cycles after accept, MemRData=0xA7 → Delay=1 for the span; CoreRData=0xA7; StallCount grows by the exact number of Delay-high cycles.
- Read with MemRValid never returning, TimeoutCycles=16 → Timeout=1 after 16 Delay cycles, still high after MemRValid arrives; Reset clears it.
- Reset asserted during RWAIT, then MemRValid pulses with 0xFF → CoreRData stays 0x00, Delay 0, FSM IDLE.

Source files
------------

// File: rtl/retro_bus_stall_if.sv
// Core-side and memory-side bus bundle for retro_bus_stall.
// The slave modport is the adapter's view; master is the core/memory side.
interface retro_bus_stall_if #(
  parameter int AddrWidth = 24,
  parameter int DataWidth = 8
);
  logic                 ClkEn;
  logic                 CoreRd;
  logic                 CoreWr;
  logic [AddrWidth-1:0] CoreAddr;
  logic [DataWidth-1:0] CoreWData;
  logic [DataWidth-1:0] CoreRData;
  logic                 Delay;
  logic                 MemReq;
  logic                 MemWe;
  logic [AddrWidth-1:0] MemAddr;
  logic [DataWidth-1:0] MemWData;
  logic                 MemReady;
  logic                 MemRValid;
  logic [DataWidth-1:0] MemRData;

  modport slave (
    input  ClkEn, CoreRd, CoreWr, CoreAddr, CoreWData, MemReady, MemRValid, MemRData,
    output CoreRData, Delay, MemReq, MemWe, MemAddr, MemWData
  );

  modport master (
    output ClkEn, CoreRd, CoreWr, CoreAddr, CoreWData, MemReady, MemRValid, MemRData,
    input  CoreRData, Delay, MemReq, MemWe, MemAddr, MemWData
  );
endinterface

// File: rtl/retro_bus_stall.sv
// Core bus adapter: posts writes through a 2-entry FIFO, stalls the core via
// Delay on reads and on write overflow, and tracks stall statistics.
module retro_bus_stall #(
  parameter int AddrWidth     = 24,
  parameter int DataWidth     = 8,
  parameter int TimeoutCycles = 4096
) (
  input  logic        Clk,
  input  logic        Reset,
  retro_bus_stall_if.slave bus,
  output logic [31:0] StallCount,
  output logic        Timeout
);

  localparam int ToW = $clog2(TimeoutCycles + 1);

  typedef enum logic [2:0] {IDLE, WFULL, RDRAIN, RISSUE, RWAIT} state_t;

  state_t               state_q;
  logic [AddrWidth-1:0] fifo_addr_q [2];
  logic [DataWidth-1:0] fifo_data_q [2];
  logic [AddrWidth-1:0] fifo_addr_d [2];
  logic [DataWidth-1:0] fifo_data_d [2];
  logic [1:0]           cnt_q, cnt_d, cnt_pop;
  logic [AddrWidth-1:0] hold_addr_q, rd_addr_q;
  logic [DataWidth-1:0] hold_data_q, rdata_q;
  logic                 delay_q;
  logic [31:0]          stall_q;
  logic [ToW-1:0]       to_cnt_q;
  logic                 timeout_q;

  logic                 rd_phase, wr_valid, pop, push, sample, core_wr, core_rd;
  logic                 fwd_hit;
  logic [DataWidth-1:0] fwd_data, push_data;
  logic [AddrWidth-1:0] push_addr;

  // The read owns the memory port only while it is being issued/awaited.
  assign rd_phase = (state_q == RISSUE) || (state_q == RWAIT);
  assign wr_valid = (cnt_q != 2'd0) && !rd_phase;
  assign pop      = wr_valid && bus.MemReady;
  assign cnt_pop  = cnt_q - {1'b0, pop};
  assign sample   = bus.ClkEn && (state_q == IDLE);
  assign core_wr  = sample && bus.CoreWr;
  assign core_rd  = sample && bus.CoreRd && !bus.CoreWr;

  assign bus.MemReq    = rd_phase ? (state_q == RISSUE) : (cnt_q != 2'd0);
  assign bus.MemWe     = wr_valid;
  assign bus.MemAddr   = rd_phase ? rd_addr_q : fifo_addr_q[0];
  assign bus.MemWData  = fifo_data_q[0];
  assign bus.Delay     = delay_q;
  assign bus.CoreRData = rdata_q;
  assign StallCount    = stall_q;
  assign Timeout       = timeout_q;

  // Newest matching entry wins, so slot 1 is checked last.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = fifo_data_q[0];
    if (cnt_q != 2'd0 && fifo_addr_q[0] == bus.CoreAddr) begin
      fwd_hit  = 1'b1;
      fwd_data = fifo_data_q[0];
    end
    if (cnt_q == 2'd2 && fifo_addr_q[1] == bus.CoreAddr) begin
      fwd_hit  = 1'b1;
      fwd_data = fifo_data_q[1];
    end
  end

  always_comb begin
    push      = 1'b0;
    push_addr = bus.CoreAddr;
    push_data = bus.CoreWData;
    if (state_q == WFULL) begin
      push      = pop;
      push_addr = hold_addr_q;
      push_data = hold_data_q;
    end else if (core_wr && cnt_pop != 2'd2) begin
      push = 1'b1;
    end
  end

  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    cnt_d       = cnt_pop;
    if (pop) begin
      fifo_addr_d[0] = fifo_addr_q[1];
      fifo_data_d[0] = fifo_data_q[1];
    end
    if (push) begin
      fifo_addr_d[cnt_pop[0]] = push_addr;
      fifo_data_d[cnt_pop[0]] = push_data;
      cnt_d                   = cnt_pop + 2'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fifo_addr_q <= '{default: '0};
      fifo_data_q <= '{default: '0};
      cnt_q       <= 2'd0;
    end else begin
      fifo_addr_q <= fifo_addr_d;
      fifo_data_q <= fifo_data_d;
      cnt_q       <= cnt_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      delay_q     <= 1'b0;
      rdata_q     <= '0;
      rd_addr_q   <= '0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (core_wr && cnt_pop == 2'd2) begin
            state_q     <= WFULL;
            delay_q     <= 1'b1;
            hold_addr_q <= bus.CoreAddr;
            hold_data_q <= bus.CoreWData;
          end else if (core_rd) begin
            if (fwd_hit) begin
              rdata_q <= fwd_data;
            end else begin
              rd_addr_q <= bus.CoreAddr;
              delay_q   <= 1'b1;
              state_q   <= (cnt_pop != 2'd0) ? RDRAIN : RISSUE;
            end
          end
        end
        WFULL: begin
          if (pop) begin
            state_q <= IDLE;
            delay_q <= 1'b0;
          end
        end
        RDRAIN: begin
          if (cnt_pop == 2'd0) state_q <= RISSUE;
        end
        RISSUE: begin
          if (bus.MemReady) state_q <= RWAIT;
        end
        RWAIT: begin
          if (bus.MemRValid) begin
            rdata_q <= bus.MemRData;
            delay_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          delay_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_q   <= '0;
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (delay_q && stall_q != '1) stall_q <= stall_q + 32'd1;
      if (!delay_q) to_cnt_q <= '0;
      else if (to_cnt_q != ToW'(TimeoutCycles)) to_cnt_q <= to_cnt_q + ToW'(1);
      if (delay_q && to_cnt_q == ToW'(TimeoutCycles - 1)) timeout_q <= 1'b1;
    end
  end

endmodule
